// File: rtl/ram_restore_pkg.sv
// Shared types and helpers for the RAM init/restore sequencer.
package ram_restore_pkg;

  typedef enum logic {
    IDLE,
    INIT
  } restore_state_e;

  typedef enum logic {
    RAM_RESET_ZERO,
    RAM_RESET_SEQ
  } ram_reset_e;

  function automatic int unsigned part_depth(input int unsigned depth, input int unsigned parts);
    return depth / parts;
  endfunction

endpackage

// File: rtl/restore_part_pick.sv
// Lowest-set-bit priority encoder used to choose the next partition to restore.
module restore_part_pick #(
  parameter int unsigned NUM_PARTS     = 4,
  parameter int unsigned NUM_PARTS_LOG = 2
) (
  input  logic [NUM_PARTS-1:0]     req_i,
  output logic [NUM_PARTS_LOG-1:0] idx_o,
  output logic                     any_o
);

  // Scan high to low so the lowest requesting index is the last one written.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < NUM_PARTS; i++) begin
      if (req_i[NUM_PARTS-1-i]) idx_o = NUM_PARTS_LOG'(NUM_PARTS-1-i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/ram_restore_ctrl.sv
// Init/restore sequencer owning RAM write port 0; writes reset patterns into
// freshly ungated partitions and otherwise passes client writes through.
module ram_restore_ctrl
  import ram_restore_pkg::*;
#(
  parameter int unsigned DEPTH         = 128,
  parameter int unsigned INDEX         = 7,
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned NUM_PARTS     = 4,
  parameter int unsigned NUM_PARTS_LOG = 2,
  parameter ram_reset_e  RESET_VAL     = RAM_RESET_ZERO,
  parameter logic [63:0] SEQ_START     = 64'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PARTS-1:0] partitionGated_i,
  input  logic                 clientWrEn_i,
  input  logic [INDEX-1:0]     clientAddrWr_i,
  input  logic [WIDTH-1:0]     clientDataWr_i,
  output logic                 ramWrEn_o,
  output logic [INDEX-1:0]     ramAddrWr_o,
  output logic [WIDTH-1:0]     ramDataWr_o,
  output logic                 clientDrop_o,
  output logic [NUM_PARTS-1:0] partitionValid_o,
  output logic                 ramReady_o
);

  localparam int unsigned PD    = part_depth(DEPTH, NUM_PARTS);
  localparam int unsigned CNT_W = INDEX - NUM_PARTS_LOG;

  restore_state_e           state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_PARTS_LOG-1:0] cur_part_q, cur_part_d;
  logic [NUM_PARTS-1:0]     pending_q, pending_d;
  logic [NUM_PARTS-1:0]     valid_q, valid_d;
  logic [NUM_PARTS-1:0]     part_gated_q;
  logic                     ready_q, ready_d;

  logic [NUM_PARTS-1:0]     ungate_edge, gate_edge, init_req;
  logic [NUM_PARTS_LOG-1:0] pick_idx;
  logic                     pick_any;
  logic [NUM_PARTS_LOG-1:0] client_part;
  logic                     client_ok, init_abort, init_last;
  logic [INDEX-1:0]         init_addr;
  logic [63:0]              seq_sum;

  assign ungate_edge = part_gated_q & ~partitionGated_i;
  assign gate_edge   = ~part_gated_q & partitionGated_i;
  assign init_req    = pending_q & ~partitionGated_i;

  restore_part_pick #(
    .NUM_PARTS     (NUM_PARTS),
    .NUM_PARTS_LOG (NUM_PARTS_LOG)
  ) u_pick (
    .req_i (init_req),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign init_addr   = {cur_part_q, cnt_q};
  assign init_abort  = partitionGated_i[cur_part_q];
  assign init_last   = (cnt_q == CNT_W'(PD - 1));
  assign seq_sum     = SEQ_START + 64'(init_addr);
  assign client_part = clientAddrWr_i[INDEX-1 -: NUM_PARTS_LOG];
  assign client_ok   = valid_q[client_part] & ~partitionGated_i[client_part]
                     & ~ungate_edge[client_part];

  always_comb begin
    ramWrEn_o    = 1'b0;
    ramAddrWr_o  = clientAddrWr_i;
    ramDataWr_o  = clientDataWr_i;
    clientDrop_o = 1'b0;
    if (state_q == INIT) begin
      ramWrEn_o    = ~init_abort;
      ramAddrWr_o  = init_addr;
      ramDataWr_o  = (RESET_VAL == RAM_RESET_SEQ) ? WIDTH'(seq_sum) : '0;
      clientDrop_o = clientWrEn_i;
    end else begin
      ramWrEn_o    = clientWrEn_i & client_ok;
      clientDrop_o = clientWrEn_i & ~client_ok;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_part_d = cur_part_q;
    pending_d  = pending_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = INIT;
          cur_part_d = pick_idx;
          cnt_d      = '0;
        end
      end
      INIT: begin
        if (init_abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (init_last) begin
          state_d               = IDLE;
          cnt_d                 = '0;
          pending_d[cur_part_q] = 1'b0;
          valid_d[cur_part_q]   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Gate/ungate edges take precedence over the sequencer's own updates.
    pending_d = (pending_d | ungate_edge) & ~gate_edge;
    valid_d   = valid_d & ~(ungate_edge | gate_edge);
    ready_d   = (state_d == IDLE) && ((pending_d & ~partitionGated_i) == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_part_q   <= '0;
      pending_q    <= '1;
      valid_q      <= '0;
      part_gated_q <= '1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_part_q   <= cur_part_d;
      pending_q    <= pending_d;
      valid_q      <= valid_d;
      part_gated_q <= partitionGated_i;
      ready_q      <= ready_d;
    end
  end

  assign partitionValid_o = valid_q;
  assign ramReady_o       = ready_q;

endmodule

// File: tb/tb_ram_restore_ctrl.sv
// Directed bench for ram_restore_ctrl: init sequencing, gating aborts and client pass-through.
module tb_ram_restore_ctrl;
  import ram_restore_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  gated;
  logic        cl_wen;
  logic [6:0]  cl_addr;
  logic [63:0] cl_data;
  logic        ramWrEn_o;
  logic [6:0]  ramAddrWr_o;
  logic [63:0] ramDataWr_o;
  logic        clientDrop_o;
  logic [3:0]  partitionValid_o;
  logic        ramReady_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  ram_restore_ctrl #(
    .DEPTH         (128),
    .INDEX         (7),
    .WIDTH         (64),
    .NUM_PARTS     (4),
    .NUM_PARTS_LOG (2),
    .RESET_VAL     (RAM_RESET_SEQ),
    .SEQ_START     (64'h10)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .partitionGated_i (gated),
    .clientWrEn_i     (cl_wen),
    .clientAddrWr_i   (cl_addr),
    .clientDataWr_i   (cl_data),
    .ramWrEn_o        (ramWrEn_o),
    .ramAddrWr_o      (ramAddrWr_o),
    .ramDataWr_o      (ramDataWr_o),
    .clientDrop_o     (clientDrop_o),
    .partitionValid_o (partitionValid_o),
    .ramReady_o       (ramReady_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  gated;
    logic        wen;
    logic [6:0]  addr;
    logic [63:0] data;
    logic        exp_wen;
    logic        exp_drop;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps through cycles c0..c1 after reset release / ungate; each partition
  // in 'order' takes one idle cycle followed by 32 restore writes.
  task automatic run_seq(input string nm, input int unsigned c0, input int unsigned c1,
                         input logic [7:0] order, input int unsigned np, input logic [3:0] basev);
    for (int unsigned c = c0; c <= c1; c++) begin
      int unsigned p, r, done;
      logic [1:0]  part;
      logic        ew;
      logic [6:0]  ea;
      logic [63:0] ed;
      logic [3:0]  ev;
      if (c != 0) tick();
      p    = c / 33;
      r    = c % 33;
      done = (p < np) ? p : np;
      ew   = 1'b0;
      ea   = '0;
      ed   = '0;
      if (p < np && r != 0) begin
        part = order[2*p +: 2];
        ea   = 7'(int'(part) * 32 + int'(r) - 1);
        ew   = 1'b1;
        ed   = 64'h10 + 64'(ea);
      end
      ev = basev;
      for (int unsigned i = 0; i < done; i++) ev[order[2*i +: 2]] = 1'b1;
      chk($sformatf("%s c=%0d", nm, c),
          128'({ramWrEn_o, ramAddrWr_o, ramDataWr_o, clientDrop_o, ramReady_o, partitionValid_o}),
          128'({ew, ea, ed, 1'b0, (p >= np), ev}));
    end
  endtask

  initial begin
    vecs[0] = '{4'b0100, 1'b1, 7'd20,  64'h1234,                1'b1, 1'b0, 1'b1};
    vecs[1] = '{4'b0100, 1'b1, 7'd70,  64'h55,                  1'b0, 1'b1, 1'b1};
    vecs[2] = '{4'b0100, 1'b1, 7'd100, 64'hDEADBEEF,            1'b1, 1'b0, 1'b1};
    vecs[3] = '{4'b0100, 1'b0, 7'd20,  64'h77,                  1'b0, 1'b0, 1'b1};
    vecs[4] = '{4'b0100, 1'b1, 7'd63,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{4'b0100, 1'b1, 7'd64,  64'h1,                   1'b0, 1'b1, 1'b1};
    vecs[6] = '{4'b1100, 1'b1, 7'd100, 64'hAB,                  1'b0, 1'b1, 1'b1};
    vecs[7] = '{4'b1100, 1'b1, 7'd100, 64'hAC,                  1'b0, 1'b1, 1'b1};
    vecs[8] = '{4'b1100, 1'b1, 7'd20,  64'hCAFE,                1'b1, 1'b0, 1'b1};
    vecs[9] = '{4'b1100, 1'b1, 7'd0,   64'h5,                   1'b1, 1'b0, 1'b1};

    reset   = 1'b1;
    gated   = 4'b0000;
    cl_wen  = 1'b1;
    cl_addr = 7'd3;
    cl_data = 64'h99;
    repeat (3) tick();
    chk("reset_state", 128'({ramWrEn_o, clientDrop_o, ramReady_o, partitionValid_o}),
        128'({1'b0, 1'b1, 1'b0, 4'b0000}));
    cl_wen  = 1'b0;
    cl_addr = '0;
    cl_data = '0;
    reset   = 1'b0;
    #1;
    run_seq("t1_full", 0, 132, 8'b11_10_01_00, 4, 4'b0000);

    reset = 1'b1;
    gated = 4'b1100;
    repeat (2) tick();
    chk("t2_reset", 128'({ramWrEn_o, ramReady_o, partitionValid_o}), 128'({1'b0, 1'b0, 4'b0000}));
    reset = 1'b0;
    #1;
    run_seq("t2_lower", 0, 66, 8'b00_00_01_00, 2, 4'b0000);
    gated = 4'b0100;
    #1;
    run_seq("t2_ungate3", 1, 33, 8'b00_00_00_11, 1, 4'b0011);

    for (int i = 0; i < 10; i++) begin
      gated   = vecs[i].gated;
      cl_wen  = vecs[i].wen;
      cl_addr = vecs[i].addr;
      cl_data = vecs[i].data;
      #2;
      if (vecs[i].exp_wen)
        chk($sformatf("t5_vec%0d", i),
            128'({ramWrEn_o, ramAddrWr_o, ramDataWr_o, clientDrop_o, ramReady_o}),
            128'({1'b1, vecs[i].addr, vecs[i].data, vecs[i].exp_drop, vecs[i].exp_ready}));
      else
        chk($sformatf("t5_vec%0d", i), 128'({ramWrEn_o, clientDrop_o, ramReady_o}),
            128'({1'b0, vecs[i].exp_drop, vecs[i].exp_ready}));
      tick();
    end
    cl_wen  = 1'b0;
    cl_addr = '0;
    cl_data = '0;
    #1;
    chk("t5_valid_after_gate3", 128'(partitionValid_o), 128'(4'b0011));

    reset = 1'b1;
    gated = 4'b0000;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    run_seq("t3_pre", 0, 5, 8'b11_10_01_00, 4, 4'b0000);
    cl_wen  = 1'b1;
    cl_addr = 7'd5;
    cl_data = 64'hAB;
    #1;
    chk("t4_client_in_init", 128'({ramWrEn_o, ramAddrWr_o, ramDataWr_o, clientDrop_o}),
        128'({1'b1, 7'd4, 64'h14, 1'b1}));
    cl_wen  = 1'b0;
    cl_addr = '0;
    cl_data = '0;
    run_seq("t3_run", 6, 44, 8'b11_10_01_00, 4, 4'b0000);
    gated = 4'b0010;
    #1;
    chk("t3_abort_wen", 128'(ramWrEn_o), 128'(1'b0));
    tick();
    chk("t3_after_abort", 128'({ramWrEn_o, partitionValid_o, ramReady_o}),
        128'({1'b0, 4'b0001, 1'b0}));
    tick();
    chk("t3_part2_start", 128'({ramWrEn_o, ramAddrWr_o, ramDataWr_o}), 128'({1'b1, 7'd64, 64'h50}));
    repeat (4) tick();
    gated = 4'b0000;
    repeat (28) tick();
    chk("t3_part2_done", 128'({ramWrEn_o, partitionValid_o, ramReady_o}),
        128'({1'b0, 4'b0101, 1'b0}));
    tick();
    chk("t3_part1_restart", 128'({ramWrEn_o, ramAddrWr_o, ramDataWr_o}), 128'({1'b1, 7'd32, 64'h30}));
    repeat (64) tick();
    chk("t3_last_write", 128'({ramWrEn_o, ramAddrWr_o, ramReady_o}), 128'({1'b1, 7'd127, 1'b0}));
    tick();
    chk("t3_all_ready", 128'({ramWrEn_o, ramReady_o, partitionValid_o}), 128'({1'b0, 1'b1, 4'b1111}));

    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    run_seq("t6_pre", 0, 8, 8'b11_10_01_00, 4, 4'b0000);
    reset = 1'b1;
    #1;
    chk("t6_async_reset", 128'({ramWrEn_o, ramReady_o, partitionValid_o}), 128'({1'b0, 1'b0, 4'b0000}));
    repeat (2) tick();
    chk("t6_held_reset", 128'(ramWrEn_o), 128'(1'b0));
    reset = 1'b0;
    #1;
    run_seq("t6_restart", 0, 132, 8'b11_10_01_00, 4, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
